hazard_filter: RTL and testbench



---
 rtl/hazard_filter.sv | 71 +++++++
 tb/tb_hazard_filter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_filter.sv
// hazard_filter: synchronise a raw level, accept it after STABLE_CYCLES stable samples, count rejected glitches
module hazard_filter #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             y,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("hazard_filter: STABLE_CYCLES must be >= 1");
  end
  typedef enum logic {STABLE, PENDING} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic s1, s2, y_nx, glitch;
  // two-flop synchroniser; only s2 is trusted downstream
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) {s1, s2} <= '0;
    else {s1, s2} <= {din, s1};
  // next state: a mismatch run either reaches the threshold or reverts as a glitch
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    y_nx = y;
    glitch = 1'b0;
    if (state == STABLE) begin
      if (s2 != y) begin
        if (STABLE_CYCLES == 1) y_nx = s2;
        else begin
          state_nx = PENDING;
          cnt_nx = CW'(1);
        end
      end
    end else if (s2 == y) begin
      glitch = 1'b1;
      state_nx = STABLE;
      cnt_nx = '0;
    end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
      y_nx = s2;
      state_nx = STABLE;
      cnt_nx = '0;
    end else cnt_nx = cnt + CW'(1);
  end
  // registered state, level, edge pulses and saturating glitch counter
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state <= STABLE;
      cnt <= '0;
      y <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      y <= y_nx;
      rise <= y_nx & ~y;
      fall <= ~y_nx & y;
      busy <= state_nx == PENDING;
      glitch_cnt <= clr_cnt ? '0 : (glitch && glitch_cnt != '1) ? glitch_cnt + 1'b1 : glitch_cnt;
    end
endmodule

// File: tb/tb_hazard_filter.sv
// tb_hazard_filter: table vectors, hand corner sequences and random stimulus against a run-length model
module tb_hazard_filter;
  logic CLK = 1'b0, nRESET = 1'b0, din = 1'b0, clr_cnt = 1'b0;
  logic [2:0] y_v, rise_v, fall_v, busy_v;
  logic [7:0] gc0, gc2;
  logic [1:0] gc1;
  int vectors = 0, miscompares = 0;

  always #5 CLK = ~CLK;

  hazard_filter #(.STABLE_CYCLES(3), .CNT_W(8)) dut0 (.CLK(CLK), .nRESET(nRESET), .din(din), .clr_cnt(clr_cnt),
    .y(y_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0]), .glitch_cnt(gc0));
  hazard_filter #(.STABLE_CYCLES(3), .CNT_W(2)) dut1 (.CLK(CLK), .nRESET(nRESET), .din(din), .clr_cnt(clr_cnt),
    .y(y_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1]), .glitch_cnt(gc1));
  hazard_filter #(.STABLE_CYCLES(1), .CNT_W(8)) dut2 (.CLK(CLK), .nRESET(nRESET), .din(din), .clr_cnt(clr_cnt),
    .y(y_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .busy(busy_v[2]), .glitch_cnt(gc2));

  int sc[3] = '{3, 3, 1};
  int gmax[3] = '{255, 3, 255};
  bit m_s1[3], m_s2[3], m_y[3], m_rise[3], m_fall[3], m_busy[3];
  int run[3], m_gc[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_y[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_busy[k] = 0;
      run[k] = 0; m_gc[k] = 0;
    end
  endfunction

  // a run of samples differing from y is accepted at length sc, or counted as a glitch if it ends early
  function automatic void model_edge(int k);
    bit old_y = m_y[k];
    bit g = 0;
    if (m_s2[k] != m_y[k]) begin
      run[k]++;
      if (run[k] >= sc[k]) begin
        m_y[k] = m_s2[k];
        run[k] = 0;
      end
    end else begin
      g = run[k] > 0;
      run[k] = 0;
    end
    m_rise[k] = m_y[k] && !old_y;
    m_fall[k] = !m_y[k] && old_y;
    m_busy[k] = run[k] > 0;
    m_gc[k] = clr_cnt ? 0 : (g && m_gc[k] < gmax[k]) ? m_gc[k] + 1 : m_gc[k];
    m_s2[k] = m_s1[k];
    m_s1[k] = din;
  endfunction

  function automatic int gc_of(int k);
    return (k == 0) ? int'(gc0) : (k == 1) ? int'(gc1) : int'(gc2);
  endfunction

  task automatic check(input int k, input string tag);
    vectors++;
    if ({y_v[k], rise_v[k], fall_v[k], busy_v[k]} !== {m_y[k], m_rise[k], m_fall[k], m_busy[k]} || gc_of(k) != m_gc[k]) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t: got y=%b rise=%b fall=%b busy=%b gc=%0d, expected y=%b rise=%b fall=%b busy=%b gc=%0d",
        tag, k, $time, y_v[k], rise_v[k], fall_v[k], busy_v[k], gc_of(k), m_y[k], m_rise[k], m_fall[k], m_busy[k], m_gc[k]);
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    for (int k = 0; k < 3; k++) model_edge(k);
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) check(k, tag);
  endtask

  typedef struct {
    bit d, c, y, r, f, b;
    int gc;
  } vec_t;

  vec_t tbl[24];
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    tbl = '{
      '{1,0,0,0,0,0,0}, '{1,0,0,0,0,0,0}, '{1,0,0,0,0,1,0}, '{1,0,0,0,0,1,0},
      '{1,0,1,1,0,0,0}, '{1,0,1,0,0,0,0}, '{0,0,1,0,0,0,0}, '{0,0,1,0,0,0,0},
      '{0,0,1,0,0,1,0}, '{0,0,1,0,0,1,0}, '{0,0,0,0,1,0,0}, '{0,0,0,0,0,0,0},
      '{1,0,0,0,0,0,0}, '{0,0,0,0,0,0,0}, '{0,0,0,0,0,1,0}, '{0,0,0,0,0,0,1},
      '{1,0,0,0,0,0,1}, '{1,0,0,0,0,0,1}, '{0,0,0,0,0,1,1}, '{0,0,0,0,0,1,1},
      '{0,0,0,0,0,0,2}, '{0,0,0,0,0,0,2}, '{0,1,0,0,0,0,0}, '{0,0,0,0,0,0,0}};
    model_reset();
    din = 1'b1;
    #12;
    for (int k = 0; k < 3; k++) check(k, "reset");
    nRESET = 1'b1;
    for (int i = 0; i < 24; i++) begin
      din = tbl[i].d;
      clr_cnt = tbl[i].c;
      tick("table");
      vectors++;
      if ({y_v[0], rise_v[0], fall_v[0], busy_v[0]} !== {tbl[i].y, tbl[i].r, tbl[i].f, tbl[i].b} || int'(gc0) != tbl[i].gc) begin
        miscompares++;
        $display("FAIL table row %0d: got y=%b rise=%b fall=%b busy=%b gc=%0d, expected y=%b rise=%b fall=%b busy=%b gc=%0d",
          i, y_v[0], rise_v[0], fall_v[0], busy_v[0], gc0, tbl[i].y, tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].gc);
      end
    end
    clr_cnt = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 3; i++) tick("midreset_pre");
    chk("midreset_busy", int'(busy_v[0]), 1);
    #2 nRESET = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) check(k, "midreset_async");
    #2 nRESET = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick("midreset_post");
      chk("midreset_rise", int'(rise_v[0]), i == 5 ? 1 : 0);
      chk("midreset_y", int'(y_v[0]), i == 5 ? 1 : 0);
    end
    din = 1'b0;
    for (int i = 0; i < 6; i++) tick("settle");
    clr_cnt = 1'b1;
    tick("clear");
    clr_cnt = 1'b0;
    for (int p = 0; p < 5; p++) begin
      din = 1'b1;
      tick("sat_pulse");
      din = 1'b0;
      for (int i = 0; i < 3; i++) tick("sat_pulse");
      chk("sat_gc_w2", int'(gc1), sat_exp[p]);
    end
    chk("sat_gc_w8", int'(gc0), 5);
    chk("sc1_no_glitch", int'(gc2), 0);
    din = 1'b1;
    tick("clr_vs_glitch");
    din = 1'b0;
    tick("clr_vs_glitch");
    tick("clr_vs_glitch");
    clr_cnt = 1'b1;
    tick("clr_vs_glitch");
    clr_cnt = 1'b0;
    chk("clr_wins_w2", int'(gc1), 0);
    chk("clr_wins_w8", int'(gc0), 0);
    for (int i = 0; i < 1500; i++) begin
      int hold = $urandom_range(1, 5);
      din = 1'($urandom_range(0, 1));
      for (int h = 0; h < hold; h++) begin
        clr_cnt = ($urandom_range(0, 63) == 0);
        tick("random");
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
